// File: rtl/cdc_led_cmd.sv
// ASCII line-command interpreter between the CDC OUT and IN byte streams; drives the RGB LED vector.
// Optional local echo of typed bytes is enabled by defining CDC_LED_CMD_ECHO_EN.
module cdc_led_cmd #(
  parameter int unsigned MAX_LEN  = 8,
  parameter logic [2:0]  LED_INIT = 3'b000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic [2:0] led_o
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_RX,
`ifdef CDC_LED_CMD_ECHO_EN
    ST_ECHO,
`endif
    ST_EXEC,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RP_OK,
    RP_ERR,
    RP_QRY
  } reply_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    led_q, led_d;
  reply_e        rep_q, rep_d;
  logic [3:0]    idx_q, idx_d;
`ifdef CDC_LED_CMD_ECHO_EN
  logic [7:0]    echo_q, echo_d;
`endif

  logic [7:0]    buf_q [MAX_LEN];
  logic          wr_en;
  logic          rx_fire;
  logic          is_led_cmd;
  logic          is_query;
  logic [3:0]    last_idx;
  logic [7:0]    reply_byte;

  function automatic logic is_bit(input logic [7:0] c);
    return (c == 8'h30) || (c == 8'h31);
  endfunction

  assign out_ready_o = (state_q == ST_RX) && !rst_i;
  assign rx_fire     = out_valid_i && out_ready_o;
  assign led_o       = led_q;

  // Only indices below len_q are meaningful; stale bytes above it are never decoded.
  assign is_led_cmd = (len_q == LW'(4))
                    && ((buf_q[0] == 8'h4C) || (buf_q[0] == 8'h6C))
                    && is_bit(buf_q[1]) && is_bit(buf_q[2]) && is_bit(buf_q[3]);
  assign is_query   = (len_q == LW'(1)) && (buf_q[0] == 8'h3F);

  always_comb begin
    last_idx = 4'd4;
    unique case (rep_q)
      RP_OK:   last_idx = 4'd3;
      RP_ERR:  last_idx = 4'd4;
      RP_QRY:  last_idx = 4'd5;
      default: last_idx = 4'd4;
    endcase
  end

  always_comb begin
    reply_byte = CH_LF;
    unique case (rep_q)
      RP_OK: begin
        case (idx_q)
          4'd0:    reply_byte = 8'h4F;
          4'd1:    reply_byte = 8'h4B;
          4'd2:    reply_byte = CH_CR;
          default: reply_byte = CH_LF;
        endcase
      end
      RP_QRY: begin
        case (idx_q)
          4'd0:    reply_byte = 8'h4C;
          4'd1:    reply_byte = {7'b0011000, led_q[0]};
          4'd2:    reply_byte = {7'b0011000, led_q[1]};
          4'd3:    reply_byte = {7'b0011000, led_q[2]};
          4'd4:    reply_byte = CH_CR;
          default: reply_byte = CH_LF;
        endcase
      end
      default: begin
        case (idx_q)
          4'd0:    reply_byte = 8'h45;
          4'd1:    reply_byte = 8'h52;
          4'd2:    reply_byte = 8'h52;
          4'd3:    reply_byte = CH_CR;
          default: reply_byte = CH_LF;
        endcase
      end
    endcase
  end

  always_comb begin
    in_valid_o = 1'b0;
    in_data_o  = 8'h00;
    if (state_q == ST_RESP) begin
      in_valid_o = 1'b1;
      in_data_o  = reply_byte;
    end
`ifdef CDC_LED_CMD_ECHO_EN
    if (state_q == ST_ECHO) begin
      in_valid_o = 1'b1;
      in_data_o  = echo_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    led_d   = led_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
`ifdef CDC_LED_CMD_ECHO_EN
    echo_d  = echo_q;
`endif
    unique case (state_q)
      ST_RX: begin
        if (rx_fire) begin
          case (out_data_i)
            CH_LF: begin
            end
            CH_BS: begin
              if (len_q != '0) len_d = len_q - LW'(1);
            end
            CH_CR: state_d = ST_EXEC;
            default: begin
              if (len_q < LW'(MAX_LEN)) begin
                wr_en = 1'b1;
                len_d = len_q + LW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end
          endcase
`ifdef CDC_LED_CMD_ECHO_EN
          if ((out_data_i != CH_CR) && (out_data_i != CH_LF)) begin
            state_d = ST_ECHO;
            echo_d  = out_data_i;
          end
`endif
        end
      end
`ifdef CDC_LED_CMD_ECHO_EN
      ST_ECHO: begin
        if (in_ready_i) state_d = ST_RX;
      end
`endif
      ST_EXEC: begin
        idx_d   = '0;
        state_d = ST_RESP;
        if (ovf_q) begin
          rep_d = RP_ERR;
        end else if (len_q == '0) begin
          state_d = ST_RX;
        end else if (is_led_cmd) begin
          rep_d = RP_OK;
          led_d = {buf_q[3][0], buf_q[2][0], buf_q[1][0]};
        end else if (is_query) begin
          rep_d = RP_QRY;
        end else begin
          rep_d = RP_ERR;
        end
      end
      ST_RESP: begin
        if (in_ready_i) begin
          if (idx_q == last_idx) begin
            state_d = ST_RX;
            len_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_RX;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RX;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      led_q   <= LED_INIT;
      rep_q   <= RP_OK;
      idx_q   <= '0;
`ifdef CDC_LED_CMD_ECHO_EN
      echo_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
`ifdef CDC_LED_CMD_ECHO_EN
      echo_q  <= echo_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (wr_en && (len_q == LW'(i))) buf_q[i] <= out_data_i;
    end
  end

endmodule
